// File: rtl/ternary_pipe_addsub_if.sv
// ternary_pipe_addsub_if: operand/result handshake bus; trits are 2-bit two's complement (N=11, Z=00, P=01).
// in_sat exists only when TERNARY_ADDSUB_SAT_EN is defined.
interface ternary_pipe_addsub_if #(parameter int WIDTH = 8);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0][1:0] in_a;
    logic [WIDTH-1:0][1:0] in_b;
    logic [1:0]            in_cin;
    logic                  in_sub;
`ifdef TERNARY_ADDSUB_SAT_EN
    logic                  in_sat;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0][1:0] out_sum;
    logic [1:0]            out_cout;
    logic                  out_ovf;
    modport master (
`ifdef TERNARY_ADDSUB_SAT_EN
        output in_sat,
`endif
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
    modport slave (
`ifdef TERNARY_ADDSUB_SAT_EN
        input  in_sat,
`endif
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/ternary_pipe_addsub.sv
// ternary_pipe_addsub: STAGES-deep pipelined balanced-ternary add/sub with valid/ready handshakes.
// Saturation on overflow is available with TERNARY_ADDSUB_SAT_EN.
module ternary_pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic clk,
    input logic rst,
    ternary_pipe_addsub_if.slave bus
);
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
    // a holds finished sum trits below the current segment and raw operand A trits above it
    typedef struct packed {
        logic                  v;
        logic                  sat;
        logic [1:0]            c;
        logic [WIDTH-1:0][1:0] a;
        logic [WIDTH-1:0][1:0] b;
    } beat_t;
    beat_t                 in_beat;
    logic                  adv;
    logic                  o_v;
    logic                  o_sat;
    logic [1:0]            o_c;
    logic [WIDTH-1:0][1:0] o_s;
    always_comb begin
        in_beat = '{v: bus.in_valid, sat: 1'b0, c: bus.in_cin, a: bus.in_a, b: bus.in_b};
        for (int i = 0; i < WIDTH; i++)
            in_beat.b[i] = bus.in_sub ? ~bus.in_b[i] + 2'b01 : bus.in_b[i];
`ifdef TERNARY_ADDSUB_SAT_EN
        in_beat.sat = bus.in_sat;
`endif
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = (k + 1) * SEG < WIDTH ? (k + 1) * SEG : WIDTH;
        beat_t                 src;
        logic [WIDTH-1:0][1:0] acc;
        logic [1:0]            cy;
        logic signed [2:0]     t;
        if (k == 0) begin : g_first
            assign src = in_beat;
        end else begin : g_next
            assign src = g_stage[k-1].g_mid.r;
        end
        // surplus stages (LO >= HI) pass the beat through untouched
        always_comb begin
            acc = src.a;
            cy  = src.c;
            t   = '0;
            for (int i = LO; i < HI; i++) begin
                t      = 3'($signed(src.a[i])) + 3'($signed(src.b[i])) + 3'($signed(cy));
                acc[i] = t > 3'sd1 ? 2'(t - 3'sd3) : t < -3'sd1 ? 2'(t + 3'sd3) : t[1:0];
                cy     = t > 3'sd1 ? 2'b01 : t < -3'sd1 ? 2'b11 : 2'b00;
            end
        end
        if (k < STAGES - 1) begin : g_mid
            beat_t r;
            always_ff @(posedge clk)
                if (rst) r <= '0;
                else if (adv) r <= '{v: src.v, sat: src.sat, c: cy, a: acc, b: src.b};
        end else begin : g_last
            always_ff @(posedge clk)
                if (rst) begin
                    o_v   <= 1'b0;
                    o_sat <= 1'b0;
                    o_c   <= 2'b00;
                    o_s   <= '0;
                end else if (adv) begin
                    o_v   <= src.v;
                    o_sat <= src.sat;
                    o_c   <= cy;
                    o_s   <= acc;
                end
        end
    end
    assign adv           = !o_v || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = o_v;
    assign bus.out_cout  = o_c;
    assign bus.out_ovf   = o_c != 2'b00;
    assign bus.out_sum   = o_sat && o_c == 2'b01 ? {WIDTH{2'b01}} :
                           o_sat && o_c == 2'b11 ? {WIDTH{2'b11}} : o_s;
endmodule

// File: tb/tb_ternary_pipe_addsub.sv
// tb_ternary_pipe_addsub: directed and random checks of ternary_pipe_addsub against an integer reference model.
module tb_ternary_pipe_addsub;
    localparam int W = 4;
    localparam int S = 2;
    typedef struct packed {
        logic [9:0] sum;
        logic [1:0] c;
        logic       o;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ternary_pipe_addsub_if #(.WIDTH(W)) bus ();
    ternary_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    exp_t q[$];
    exp_t cur;
    logic       sw_v = 1'b0;
    logic       sw_sub = 1'b0;
    logic [9:0] sw_a = '0;
    logic [9:0] sw_b = '0;
    logic [1:0] sw_cin = '0;
    logic       sw_ov [5];
    logic [9:0] sw_sum [5];
    logic [1:0] sw_c [5];
    for (genvar s = 1; s <= 5; s++) begin : g_sw
        ternary_pipe_addsub_if #(.WIDTH(5)) sif ();
        ternary_pipe_addsub #(.WIDTH(5), .STAGES(s)) dut_sw (.clk(clk), .rst(rst), .bus(sif));
        assign sif.in_valid  = sw_v;
        assign sif.in_a      = sw_a;
        assign sif.in_b      = sw_b;
        assign sif.in_cin    = sw_cin;
        assign sif.in_sub    = sw_sub;
        assign sif.out_ready = 1'b1;
`ifdef TERNARY_ADDSUB_SAT_EN
        assign sif.in_sat    = 1'b0;
`endif
        assign sw_ov[s-1]  = sif.out_valid;
        assign sw_sum[s-1] = sif.out_sum;
        assign sw_c[s-1]   = sif.out_cout;
    end
    function automatic logic [1:0] trit(int v);
        return v > 0 ? 2'b01 : v < 0 ? 2'b11 : 2'b00;
    endfunction
    function automatic logic [9:0] enc(int v);
        logic [9:0] e;
        int d;
        for (int i = 0; i < 5; i++) begin
            d = ((v % 3) + 3) % 3;
            d = d == 2 ? -1 : d;
            e[2*i+:2] = trit(d);
            v = (v - d) / 3;
        end
        return e;
    endfunction
    function automatic exp_t model(int w, int a, int b, int c, bit sub, bit sat);
        int p3, m, r, co, s;
        p3 = 1;
        for (int i = 0; i < w; i++) p3 *= 3;
        m  = (p3 - 1) / 2;
        r  = a + (sub ? -b : b) + c;
        co = r > m ? 1 : r < -m ? -1 : 0;
        s  = sat && co != 0 ? co * m : r - co * p3;
        return '{sum: enc(s), c: trit(co), o: co != 0};
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic drive(int a, int b, int c, bit sub, bit sat);
        logic [9:0] ea, eb;
        ea = enc(a);
        eb = enc(b);
        bus.in_a   = ea[2*W-1:0];
        bus.in_b   = eb[2*W-1:0];
        bus.in_cin = trit(c);
        bus.in_sub = sub;
`ifdef TERNARY_ADDSUB_SAT_EN
        bus.in_sat = sat;
`endif
        cur = model(W, a, b, c, sub, sat);
    endtask
    task automatic step();
        exp_t e;
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("spurious_out", bus.out_valid, 0);
            else begin
                e = q.pop_front();
                n_out++;
                chk("out_sum", bus.out_sum, e.sum);
                chk("out_cout", bus.out_cout, e.c);
                chk("out_ovf", bus.out_ovf, e.o);
            end
        end
        if (!rst && bus.in_valid && bus.in_ready) q.push_back(cur);
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic run_one(int a, int b, int c, bit sub, bit sat);
        exp_t e;
        drive(a, b, c, sub, sat);
        e = cur;
        bus.in_valid = 1'b1;
        for (int k = 0; k < S; k++) begin
            step();
            bus.in_valid = 1'b0;
            if (k < S - 1) chk("latency_early", bus.out_valid, 0);
        end
        chk("latency_valid", bus.out_valid, 1);
        chk("direct_sum", bus.out_sum, e.sum);
        chk("direct_cout", bus.out_cout, e.c);
        chk("direct_ovf", bus.out_ovf, e.o);
        step();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int i, c, n0, a, b, ci;
        bit sub, hold;
        logic [9:0] hold_val;
        bit hist_v [30];
        exp_t hist_e [30];
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
`ifdef TERNARY_ADDSUB_SAT_EN
        bus.in_sat    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_ready", bus.in_ready, 1);
        chk("reset_sum", bus.out_sum, 0);
        chk("reset_cout", bus.out_cout, 0);
        chk("reset_ovf", bus.out_ovf, 0);
        run_one(13, 14, 0, 0, 0);
        run_one(5, 12, 0, 1, 0);
        run_one(-40, 1, 0, 1, 0);
        run_one(40, 1, 0, 0, 0);
        run_one(-40, -1, 0, 0, 0);
        run_one(40, -40, 1, 1, 0);
`ifdef TERNARY_ADDSUB_SAT_EN
        run_one(40, 1, 0, 0, 1);
        run_one(-40, 1, 0, 1, 1);
`endif
        i = 0;
        c = 0;
        hold = 0;
        hold_val = '0;
        n0 = n_out;
        while ((i < 6 || q.size() != 0) && c < 40) begin
            bus.in_valid = i < 6;
            if (i < 6) drive(i + 1, i + 1, 0, 0, 0);
            bus.out_ready = !(c >= 3 && c <= 6);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                chk("bp_in_ready", bus.in_ready, 0);
                if (hold) chk("bp_hold", {bus.out_sum, bus.out_cout}, hold_val);
                hold = 1;
                hold_val = {bus.out_sum, bus.out_cout};
            end else hold = 0;
            n_cmp = n_cmp;
            if (bus.in_valid && bus.in_ready) begin
                step();
                i++;
            end else step();
            c++;
        end
        chk("bp_count", n_out - n0, 6);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 20 + S; j++) begin
            bus.in_valid = j < 20;
            if (j < 20) begin
                a   = int'($urandom_range(80)) - 40;
                b   = int'($urandom_range(80)) - 40;
                ci  = int'($urandom_range(2)) - 1;
                sub = 1'($urandom_range(1));
                drive(a, b, ci, sub, 0);
            end
            #1;
            chk("tp_in_ready", bus.in_ready, 1);
            if (j >= S) chk("tp_out_valid", bus.out_valid, 1);
            step();
        end
        chk("tp_drained", q.size(), 0);
        bus.in_valid = 1'b0;
        drive(5, 5, 0, 0, 0);
        bus.in_valid = 1'b1;
        step();
        drive(7, 7, 0, 0, 0);
        step();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        drive(9, 9, 0, 0, 0);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        q.delete();
        #1;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_ready", bus.in_ready, 1);
        run_one(3, -1, 0, 0, 0);
        repeat (4) step();
        for (int t = 0; t < 30; t++) begin
            a   = int'($urandom_range(242)) - 121;
            b   = int'($urandom_range(242)) - 121;
            ci  = int'($urandom_range(2)) - 1;
            sub = 1'($urandom_range(1));
            hist_v[t] = 1'($urandom_range(3) != 0);
            hist_e[t] = model(5, a, b, ci, sub, 0);
            sw_v   = hist_v[t];
            sw_a   = enc(a);
            sw_b   = enc(b);
            sw_cin = trit(ci);
            sw_sub = sub;
            @(posedge clk);
            @(negedge clk);
            for (int s = 1; s <= 5; s++) begin
                if (t - s + 1 >= 0) begin
                    chk($sformatf("sweep%0d_valid", s), sw_ov[s-1], hist_v[t-s+1]);
                    if (hist_v[t-s+1]) begin
                        chk($sformatf("sweep%0d_sum", s), sw_sum[s-1], hist_e[t-s+1].sum);
                        chk($sformatf("sweep%0d_cout", s), sw_c[s-1], hist_e[t-s+1].c);
                    end
                end else chk($sformatf("sweep%0d_idle", s), sw_ov[s-1], 0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ternary_pipe_addsub.md
Name: ternary_pipe_addsub

Overview:
- Pipelined, parametrised balanced-ternary adder/subtractor with valid/ready handshakes on both sides.
- Successor to the single-cycle ripple adder. Splits the WIDTH-trit carry chain into STAGES registered segments, adds a per-transaction add/sub mode, and flags overflow.
- Sits in the ALU datapath between operand fetch and writeback. Sustains one operation per cycle when not back-pressured.

Parameters:
- WIDTH, 8, operand width in trits (>=1).
- STAGES, 2, number of pipeline register stages (1..WIDTH); also the latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH x trit_t  operand A, trit 0 = LSB.
- in_b  input  WIDTH x trit_t  operand B.
- in_cin  input  trit_t  carry-in trit (N/Z/P).
- in_sub  input  1  1 = compute A - B + cin; 0 = A + B + cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH x trit_t  result trits.
- out_cout  output  trit_t  carry-out trit of the MSB.
- out_ovf  output  1  1 when out_cout != Z (result outside ±(3^WIDTH-1)/2).

Behaviour:
- Reset: clears every stage valid bit. out_valid=0, out_sum all Z, out_cout=Z, out_ovf=0. in_ready=1 in the first cycle after reset.
- Subtract: B is trit-wise negated (N<->P, Z unchanged) on entry, then added. cin is applied unmodified in both modes.
- Segmentation: SEG = ceil(WIDTH/STAGES) trits per stage. Stage k adds trits [k*SEG .. min((k+1)*SEG,WIDTH)-1] using the carry registered by stage k-1. Stage 0 uses in_cin.
- Unprocessed upper operand trits and completed lower sum trits travel with each beat through the stage registers.
- The last stage may be shorter than SEG. If STAGES exceeds the number of non-empty segments, the surplus stages are pure delay registers, so latency stays exactly STAGES.
- Pipeline advance: advance = !out_valid || out_ready; in_ready = advance (combinational).
- All stages shift together on advance. An accept happens when in_valid && in_ready; otherwise a bubble (valid=0) enters stage 0.
- Bubbles are not compressed.
- Latency: a beat accepted in cycle t appears at the output in cycle t+STAGES if no stall occurs.
- Stalls: when out_valid && !out_ready, all stage registers and outputs hold. in_ready=0.
- Outputs never change while out_valid=1 and out_ready=0.
- Simultaneous accept and drain in the same cycle is allowed: full throughput, no bubble inserted.
- out_ovf/out_cout: when the true result is outside range, out_sum holds the wrapped value, i.e. result - cout*3^WIDTH. Example: WIDTH=4, 40+1 gives sum -40, cout P.
- Reset mid-operation: all in-flight beats are discarded with no output. The same cycle's in_valid is ignored.
- Input X/invalid trit codes: the result is undefined but must not corrupt other beats.

Optional Feature:
- Macro TERNARY_ADDSUB_SAT_EN.
- Defined: adds input port in_sat (1 bit), carried with the beat. When in_sat=1 and cout=P, out_sum is forced to all-P (+max). When in_sat=1 and cout=N, out_sum is forced to all-N (-max).
- out_cout and out_ovf still report the raw carry.
- Not defined: no in_sat port; result always wraps as described above.

Test Plan:
- WIDTH=4, STAGES=2, out_ready=1, add 13+14 cin=Z -> out_valid exactly 2 cycles later; sum=27; cout=Z; ovf=0.
- Sub, A=5, B=12, cin=Z -> sum=-7, ovf=0. Sub, A=-40, B=1, cin=Z -> sum=+40, cout=N, ovf=1.
- Overflow add, A=40, B=1 -> sum=-40, cout=P, ovf=1. With TERNARY_ADDSUB_SAT_EN and in_sat=1 -> sum=+40 (all P), cout=P, ovf=1.
- Back-pressure: stream 6 beats (i+1)+(i+1) for i=0..5, holding out_ready=0 for cycles 3..6.
  - Outputs must hold stable during the stall, in_ready=0 during the stall.
  - All 6 results (2,4,...,12) appear in order, none lost or duplicated.
- Full throughput with out_ready=1 and in_valid=1 for 20 random beats -> one result per cycle, matching the reference model.
- Sweep STAGES=1..WIDTH for WIDTH=5.
- Reset mid-operation: assert rst for 1 cycle with 2 beats in flight.
  - Next cycle: out_valid=0 and in_ready=1.
  - Neither in-flight result ever appears.
  - A new beat 3+(-1) yields sum=2 after STAGES cycles.
